// File: rtl/reg_skid_stage.sv
// Two-entry valid/ready stage (main + skid register) feeding the write-enabled register banks.
// in_ready and level are flop outputs, so out_ready never reaches in_ready combinationally.
//
// state | meaning
// ------+---------------------------------------------------
// EMPTY | nothing stored, out_valid=0, in_ready=1, level=0
// BUSY  | one word in main, out_valid=1, in_ready=1, level=1
// FULL  | main + skid hold words, out_valid=1, in_ready=0, level=2
module reg_skid_stage #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       level_q, level_d;
  logic             valid_w;
  logic             in_fire;
  logic             out_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      level_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      level_q    <= level_d;
    end
  end

  always_comb begin
    valid_w  = (state_q == BUSY) || (state_q == FULL);
    in_fire  = in_valid & in_ready_q;
    out_fire = valid_w & out_ready;
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;

    if (flush) begin
      // Handshakes in a flush cycle are dropped; data registers keep their contents.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Registered from the next state so level never shows the illegal encoding.
    level_d    = 2'(state_d);
    in_ready_d = (state_d != FULL);
  end

  assign out_data  = main_q;
  assign out_valid = valid_w;
  assign in_ready  = in_ready_q;
  assign level     = level_q;

endmodule

// File: tb/tb_reg_skid_stage.sv
// Bench for reg_skid_stage: queue-based 2-deep FIFO model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reg_skid_stage;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         flush;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   level;

  int vectors;
  int miscompares;

  logic [W-1:0] mq[$];
  logic [W-1:0] shown;

  logic         stall_prev;
  logic [W-1:0] data_prev;
  logic         chk_stable;

  reg_skid_stage #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain FIFO of at most two words; the front word is what the consumer sees.
  initial begin
    shown = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        shown = '0;
      end else if (flush) begin
        mq.delete();
      end else begin
        bit acc, pop;
        acc = in_valid && (mq.size() < 2);
        pop = out_ready && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
        if (mq.size() > 0) shown = mq[0];
      end
    end
  end

  // Per-cycle comparison against the model, plus explicit stall stability.
  initial begin
    stall_prev = 1'b0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      chk("level", 32'(level), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("out_data", 32'(out_data), 32'(shown));
      if (chk_stable && stall_prev) chk("stall_stable", 32'(out_data), 32'(data_prev));
      stall_prev = out_valid && !out_ready && !flush && rst;
      data_prev  = out_data;
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  // Advance one edge; outputs are settled 2 time units after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    vectors    = 0;
    miscompares = 0;
    chk_stable = 1'b0;
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_level", 32'(level), 32'd0);
    rst = 1'b1;

    // Reset mid-stream from FULL
    drive(1'b1, 8'hA1, 1'b0, 1'b0); step();
    drive(1'b1, 8'hA2, 1'b0, 1'b0); step();
    chk("full_level", 32'(level), 32'd2);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_data", 32'(out_data), 32'hA1);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'h00);
    #3 rst = 1'b1;
    drive(1'b1, 8'h33, 1'b0, 1'b0); step();
    chk("post_rst_data", 32'(out_data), 32'h33);
    chk("post_rst_level", 32'(level), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    chk("post_rst_drain", 32'(level), 32'd0);

    // Streaming 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0); step();
      chk("stream_data", 32'(out_data), 32'(i));
      chk("stream_level", 32'(level), 32'd1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    chk("stream_empty", 32'(out_valid), 32'd0);

    // Back-pressure fill
    drive(1'b1, 8'h11, 1'b0, 1'b0); step();
    chk("fill1_level", 32'(level), 32'd1);
    chk("fill1_data", 32'(out_data), 32'h11);
    drive(1'b1, 8'h22, 1'b0, 1'b0); step();
    chk("fill2_level", 32'(level), 32'd2);
    chk("fill2_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 8'h33, 1'b0, 1'b0); step(); step();
    chk("fill3_level", 32'(level), 32'd2);
    chk("fill3_data", 32'(out_data), 32'h11);

    // Drain: 0x11, 0x22, 0x33 in order
    drive(1'b1, 8'h33, 1'b1, 1'b0); step();
    chk("drain1_data", 32'(out_data), 32'h22);
    chk("drain1_level", 32'(level), 32'd1);
    chk("drain1_in_ready", 32'(in_ready), 32'd1);
    step();
    chk("drain2_data", 32'(out_data), 32'h33);
    chk("drain2_level", 32'(level), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0); step();
    chk("drain3_level", 32'(level), 32'd0);
    chk("drain3_valid", 32'(out_valid), 32'd0);

    // Flush with simultaneous handshake while FULL
    drive(1'b1, 8'h55, 1'b0, 1'b0); step();
    drive(1'b1, 8'h66, 1'b0, 1'b0); step();
    chk("pre_flush_level", 32'(level), 32'd2);
    drive(1'b1, 8'h77, 1'b1, 1'b1); step();
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_flush_valid", 32'(out_valid), 32'd0);
    end

    // Random traffic against the model
    chk_stable = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 63) == 0));
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
